sc_mmio_unit: RTL and testbench

Parametrised memory-mapped I/O unit for the single-cycle computer. It sits beside the data memory on the CPU data bus and claims one address window. It replaces the fixed switch/key/LED/six-digit-HEX decoding with configurable channel counts, synchronised and debounced keys, sticky key-press events and per-digit blanking. It decodes its window, holds the output registers, drives active-low seven-segment patterns and returns read data in the same cycle.

---
 rtl/sc_mmio_unit.sv | 159 +++++++++++++++
 tb/tb_sc_mmio_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_mmio_unit.sv
// sc_mmio_unit: memory-mapped switch/key/LED/seven-segment unit on the CPU data bus.
// The window is claimed by addr[31:8]; the register index is addr[7:2], so the low
// byte of IO_BASE does not shift the register map. Reads are combinational, writes
// land on the rising edge. Keys are synchronised, debounced and latched as sticky
// press events that software clears by writing 1.
module sc_mmio_unit #(
   parameter logic [31:0] IO_BASE         = 32'h0000_0080,
   parameter int          NUM_SW          = 10,
   parameter int          NUM_KEY         = 3,
   parameter int          NUM_LED         = 10,
   parameter int          NUM_HEX         = 6,
   parameter int          DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [31:0]          addr,
   input  logic [31:0]          wdata,
   input  logic                 we,
   output logic                 io_sel,
   output logic [31:0]          rdata,
   input  logic [NUM_SW-1:0]    sw,
   input  logic [NUM_KEY-1:0]   key,
   output logic [NUM_LED-1:0]   led,
   output logic [7*NUM_HEX-1:0] hex
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SW-1:0]    sw_meta, sw_sync;
   logic [NUM_KEY-1:0]   key_meta, key_sync;
   logic [NUM_KEY-1:0]   key_level, key_event, key_rise, event_clr;
   logic [CW-1:0]        deb_cnt [NUM_KEY];
   logic [NUM_LED-1:0]   led_reg;
   logic [4*NUM_HEX-1:0] hex_value;
   logic [NUM_HEX-1:0]   hex_blank;
   logic [5:0]           reg_idx;
   logic                 wr_en;
   logic                 unused_bits;

   assign io_sel      = (addr[31:8] == IO_BASE[31:8]);
   assign reg_idx     = addr[7:2];
   assign wr_en       = we && io_sel;
   assign event_clr   = (wr_en && reg_idx == 6'h02) ? wdata[NUM_KEY-1:0] : '0;
   assign led         = led_reg;
   assign unused_bits = ^{addr[1:0], wdata};

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      s = 7'h7F;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Two-flop synchronisers; keys are inverted on entry so 1 means pressed.
   always_ff @(posedge clock) begin
      if (reset) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         key_meta <= '0;
         key_sync <= '0;
      end else begin
         sw_meta  <= sw;
         sw_sync  <= sw_meta;
         key_meta <= ~key;
         key_sync <= key_meta;
      end
   end

   // Per-key debouncer: count while synced value disagrees, accept after DEBOUNCE_CYCLES.
   always_ff @(posedge clock) begin
      if (reset) begin
         key_level <= '0;
         for (int k = 0; k < NUM_KEY; k++) deb_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_KEY; k++) begin
            if (key_sync[k] == key_level[k]) begin
               deb_cnt[k] <= '0;
            end else if (deb_cnt[k] == CNT_LAST) begin
               deb_cnt[k]   <= '0;
               key_level[k] <= key_sync[k];
            end else begin
               deb_cnt[k] <= deb_cnt[k] + CW'(1);
            end
         end
      end
   end

   // A rise is the edge on which the debounced level is about to flip from 0 to 1.
   always_comb begin
      key_rise = '0;
      for (int k = 0; k < NUM_KEY; k++)
         key_rise[k] = !key_level[k] && key_sync[k] && (deb_cnt[k] == CNT_LAST);
   end

   // Sticky press events; a new press beats a simultaneous write-1-to-clear.
   always_ff @(posedge clock) begin
      if (reset) key_event <= '0;
      else       key_event <= (key_event & ~event_clr) | key_rise;
   end

   // Software-writable output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         led_reg   <= '0;
         hex_value <= '0;
         hex_blank <= '1;
      end else if (wr_en) begin
         case (reg_idx)
            6'h03:   led_reg   <= wdata[NUM_LED-1:0];
            6'h04:   hex_value <= wdata[4*NUM_HEX-1:0];
            6'h05:   hex_blank <= wdata[NUM_HEX-1:0];
            default: ;
         endcase
      end
   end

   // Combinational read mux, zero-extended, zero outside the window.
   always_comb begin
      rdata = '0;
      if (io_sel) begin
         case (reg_idx)
            6'h00:   rdata[NUM_SW-1:0]    = sw_sync;
            6'h01:   rdata[NUM_KEY-1:0]   = key_level;
            6'h02:   rdata[NUM_KEY-1:0]   = key_event;
            6'h03:   rdata[NUM_LED-1:0]   = led_reg;
            6'h04:   rdata[4*NUM_HEX-1:0] = hex_value;
            6'h05:   rdata[NUM_HEX-1:0]   = hex_blank;
            default: rdata = '0;
         endcase
      end
   end

   // Active-low seven-segment drive with per-digit blanking.
   always_comb begin
      hex = '1;
      for (int i = 0; i < NUM_HEX; i++)
         hex[7*i +: 7] = hex_blank[i] ? 7'h7F : seg7(hex_value[4*i +: 4]);
   end

endmodule

// File: tb/tb_sc_mmio_unit.sv
// Bench for sc_mmio_unit: directed steps followed by a randomized phase, all checked
// against a behavioural model of registers, key debouncing (window of agreeing
// samples) and sticky events.
module tb_sc_mmio_unit;
   localparam logic [31:0] IO_BASE = 32'h0000_0080;
   localparam int NSW  = 10;
   localparam int NKEY = 3;
   localparam int NLED = 10;
   localparam int NHEX = 8;
   localparam int DEB  = 4;
   localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              we    = 1'b0;
   logic [31:0]       addr  = 32'h0;
   logic [31:0]       wdata = 32'h0;
   logic              io_sel;
   logic [31:0]       rdata;
   logic [NSW-1:0]    sw    = '0;
   logic [NKEY-1:0]   key   = '1;
   logic [NLED-1:0]   led;
   logic [7*NHEX-1:0] hex;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   logic [NLED-1:0]   m_led;
   logic [4*NHEX-1:0] m_hexv;
   logic [NHEX-1:0]   m_blank;
   logic [NKEY-1:0]   m_evt, m_deb;
   logic [NSW-1:0]    sw_d1, sw_d2;
   logic [63:0]       hist [NKEY];

   sc_mmio_unit #(.IO_BASE(IO_BASE), .NUM_SW(NSW), .NUM_KEY(NKEY), .NUM_LED(NLED),
                  .NUM_HEX(NHEX), .DEBOUNCE_CYCLES(DEB)) dut (
      .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
      .io_sel(io_sel), .rdata(rdata), .sw(sw), .key(key), .led(led), .hex(hex));

   always #5 clock = ~clock;

   function automatic logic [31:0] ra(input int idx);
      return {IO_BASE[31:8], 8'(idx << 2)};
   endfunction

   function automatic logic [7*NHEX-1:0] exp_hex();
      logic [7*NHEX-1:0] h;
      for (int i = 0; i < NHEX; i++)
         h[7*i +: 7] = m_blank[i] ? 7'h7F : SEG[m_hexv[4*i +: 4]];
      return h;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[31:8] != IO_BASE[31:8]) return 32'h0;
      case (a[7:2])
         6'd0:    return 32'(sw_d2);
         6'd1:    return 32'(m_deb);
         6'd2:    return 32'(m_evt);
         6'd3:    return 32'(m_led);
         6'd4:    return 32'(m_hexv);
         6'd5:    return 32'(m_blank);
         default: return 32'h0;
      endcase
   endfunction

   // Debounced level flips once the last DEB synchronised samples all disagree with it;
   // a synchronised sample seen at an edge is the raw key from two edges earlier.
   task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [NKEY-1:0] k,
                             input logic [NSW-1:0] s);
      logic [NKEY-1:0] clr, rise;
      logic differ;
      if (r) begin
         m_led = '0; m_hexv = '0; m_blank = '1; m_evt = '0; m_deb = '0;
         sw_d1 = '0; sw_d2 = '0;
         for (int i = 0; i < NKEY; i++) hist[i] = '0;
      end else begin
         clr = '0; rise = '0;
         sw_d2 = sw_d1; sw_d1 = s;
         if (w) begin
            case (a[7:2])
               6'd2:    clr     = d[NKEY-1:0];
               6'd3:    m_led   = d[NLED-1:0];
               6'd4:    m_hexv  = d[4*NHEX-1:0];
               6'd5:    m_blank = d[NHEX-1:0];
               default: ;
            endcase
         end
         for (int i = 0; i < NKEY; i++) begin
            hist[i] = {hist[i][62:0], ~k[i]};
            differ = 1'b1;
            for (int j = 2; j <= DEB + 1; j++)
               if (hist[i][j] == m_deb[i]) differ = 1'b0;
            if (differ) begin
               rise[i]  = ~m_deb[i];
               m_deb[i] = ~m_deb[i];
            end
         end
         m_evt = (m_evt & ~clr) | rise;
      end
   endtask

   task automatic tick();
      logic w;
      logic [31:0] a, d;
      logic [NKEY-1:0] k;
      logic [NSW-1:0] s;
      logic r;
      w = we && (addr[31:8] == IO_BASE[31:8]);
      a = addr; d = wdata; k = key; s = sw; r = reset;
      @(posedge clock);
      model_step(r, w, a, d, k, s);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_read(input string tag, input logic [31:0] a);
      we = 1'b0; addr = a;
      #1;
      chk({tag, "_rdata"}, 64'(rdata), 64'(model_read(a)));
      chk({tag, "_io_sel"}, 64'(io_sel), 64'(a[31:8] == IO_BASE[31:8]));
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_led"}, 64'(led), 64'(m_led));
      chk({tag, "_hex"}, 64'(hex), 64'(exp_hex()));
   endtask

   task automatic wr(input int idx, input logic [31:0] d);
      addr = ra(idx); wdata = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic rd_const(input string tag, input int idx, input logic [31:0] exp);
      we = 1'b0; addr = ra(idx);
      #1;
      chk(tag, 64'(rdata), 64'(exp));
   endtask

   initial begin
      logic [31:0] a;
      int op;

      // reset state
      reset = 1'b1;
      tick();
      chk("rst_led", 64'(led), 64'h0);
      chk("rst_hex", 64'(hex), {8'h0, {NHEX{7'h7F}}});
      tick(); tick();
      reset = 1'b0;
      tick();
      rd_const("rst_key_level", 1, 32'h0);
      rd_const("rst_key_event", 2, 32'h0);
      addr = 32'h0000_0100; #1;
      chk("out_io_sel", 64'(io_sel), 64'h0);
      chk("out_rdata", 64'(rdata), 64'h0);

      // output registers, including read-old-on-write
      addr = ra(3); wdata = 32'h3FF; we = 1'b1; #1;
      chk("rd_during_wr", 64'(rdata), 64'h0);
      tick(); we = 1'b0;
      chk("led_3ff", 64'(led), 64'h3FF);
      wr(4, 32'h0054_3210);
      wr(5, 32'h0);
      chk("hex_digits", 64'(hex[41:0]), 64'({7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}));
      check_outputs("hex_wr");
      rd_const("led_rd", 3, 32'h3FF);
      wr(3, 32'hFFFF_FFFF);
      rd_const("led_trunc", 3, 32'h3FF);
      wr(5, 32'h80);
      chk("blank_d7", 64'(hex[55:49]), 64'h7F);
      check_outputs("blank");
      wr(6, 32'hFFFF_FFFF);
      rd_const("unmapped_rd", 6, 32'h0);
      for (int i = 0; i < 6; i++) check_read("after_unmapped", ra(i));
      check_outputs("after_unmapped");

      // switch path latency
      sw = 10'h2A5;
      tick();
      rd_const("sw_1edge", 0, 32'h0);
      tick();
      rd_const("sw_2edge", 0, 32'h2A5);

      // glitch on key[0] shorter than the debounce window
      key[0] = 1'b0;
      repeat (3) tick();
      key[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         rd_const("glitch_level", 1, 32'h0);
      end

      // held press: level and event exactly 2+DEB edges after the fall
      key[0] = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         rd_const("press_level", 1, (i >= 6) ? 32'h1 : 32'h0);
         rd_const("press_event", 2, (i >= 6) ? 32'h1 : 32'h0);
      end

      // W1C and set-beats-clear on key[1]
      key[1] = 1'b0;
      repeat (6) tick();
      rd_const("evt_both", 2, 32'h3);
      wr(2, 32'h1);
      rd_const("evt_w1c", 2, 32'h2);
      key[1] = 1'b1;
      repeat (8) tick();
      rd_const("release_level", 1, 32'h1);
      rd_const("release_noevt", 2, 32'h2);
      wr(2, 32'h2);
      rd_const("evt_cleared", 2, 32'h0);
      key[1] = 1'b0;
      repeat (5) tick();
      rd_const("evt_pre", 2, 32'h0);
      wr(2, 32'h2);
      rd_const("set_wins", 2, 32'h2);
      wr(2, 32'h2);
      rd_const("evt_clr2", 2, 32'h0);

      // reset during a debounce in progress
      key = '1;
      repeat (8) tick();
      key[2] = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rd_const("midrst_level", 1, 32'h0);
      rd_const("midrst_event", 2, 32'h0);
      check_outputs("midrst");
      repeat (5) tick();
      rd_const("requal_5", 1, 32'h0);
      tick();
      rd_const("requal_6", 1, 32'h4);
      rd_const("requal_evt", 2, 32'h4);

      // randomized phase against the model
      for (int c = 0; c < 600; c++) begin
         check_read("rnd", ra($urandom_range(0, 7)));
         check_outputs("rnd");
         if ($urandom_range(0, 3) == 0) key[$urandom_range(0, NKEY-1)] ^= 1'b1;
         if ($urandom_range(0, 15) == 0) sw = NSW'($urandom());
         reset = ($urandom_range(0, 149) == 0);
         op = $urandom_range(0, 3);
         wdata = $urandom();
         if (op == 1) begin
            addr = ra($urandom_range(0, 7)); we = 1'b1;
         end else if (op == 2) begin
            a = $urandom();
            if (a[31:8] == IO_BASE[31:8]) a[31] = ~a[31];
            addr = a; we = 1'b1;
         end else begin
            addr = $urandom(); we = 1'b0;
         end
         tick();
         we = 1'b0;
         reset = 1'b0;
      end
      check_outputs("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
